mcx_core_param: RTL and testbench

- Parametrised successor to the MCX micro-controller core: fetches, decodes and executes one instruction per cycle from an internal writable program store.
- Adds N configurable simple-I/O ports, conditional execution (+/− flags), test instructions, saturating arithmetic, sleep, and a program-load port.
- Sits between the board-level pin wrappers and the program loader; supersedes the separate fixed-depth program memory.

---
 rtl/mcx_core_param.sv | 180 ++++++++++++++++++
 tb/tb_mcx_core_param.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/mcx_core_param.sv
// MCX micro-controller core: single-cycle fetch/decode/execute from a writable program store,
// with saturating accumulator, conditional execution, simple-I/O ports and a sleep stall.
module mcx_core_param #(
    parameter int NUM_PORTS  = 2,
    parameter int PORT_W     = 7,
    parameter int DATA_W     = 11,
    parameter int ACC_MAX    = 999,
    parameter int PROG_DEPTH = 16,
    parameter int AW         = $clog2(PROG_DEPTH)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          run,
    input  logic                          prog_we,
    input  logic [AW-1:0]                 prog_addr,
    input  logic [29:0]                   prog_wdata,
    input  logic [AW-1:0]                 prog_last,
    input  logic [NUM_PORTS*PORT_W-1:0]   p_in,
    output logic [NUM_PORTS*PORT_W-1:0]   p_out,
    output logic [NUM_PORTS-1:0]          p_oe,
    output logic [AW-1:0]                 pc,
    output logic signed [DATA_W-1:0]      acc,
    output logic                          flag_p,
    output logic                          flag_m,
    output logic                          sleeping
);

    localparam int SW = 2*DATA_W + 2;
    localparam logic signed [SW-1:0]     MAX_W  = SW'(ACC_MAX);
    localparam logic signed [SW-1:0]     MIN_W  = -MAX_W;
    localparam logic signed [DATA_W-1:0] PORT_MAX = DATA_W'(100);
    localparam logic [11:0]              REG_ACC  = 12'h801;
    localparam logic [11:0]              REG_PORT = 12'h810;

    typedef enum logic [3:0] {
        OP_NOP = 4'h0, OP_MOV = 4'h1, OP_JMP = 4'h2, OP_ADD = 4'h3,
        OP_SUB = 4'h4, OP_MUL = 4'h5, OP_NOT = 4'h6, OP_TEQ = 4'h7,
        OP_TGT = 4'h8, OP_TLT = 4'h9, OP_SLP = 4'hA
    } op_t;

    logic [29:0] mem [PROG_DEPTH];

    logic [29:0]                instr;
    logic [1:0]                 cond;
    op_t                        op;
    logic [11:0]                opa, opb;
    logic signed [DATA_W-1:0]   val_a, val_b;
    logic signed [SW-1:0]       wa, wb, sum, diff, prod;
    logic [PORT_W-1:0]          port_val;
    logic                       exec;
    logic [AW-1:0]              seq_next;
    logic [DATA_W-1:0]          slp_cnt;

    function automatic logic signed [DATA_W-1:0] sat(input logic signed [SW-1:0] v);
        logic signed [SW-1:0] c;
        if (v > MAX_W)
            c = MAX_W;
        else if (v < MIN_W)
            c = MIN_W;
        else
            c = v;
        return c[DATA_W-1:0];
    endfunction

    function automatic logic signed [DATA_W-1:0] operand(
        input logic [11:0]                 code,
        input logic signed [DATA_W-1:0]    cur_acc,
        input logic [NUM_PORTS*PORT_W-1:0] pins
    );
        logic signed [SW-1:0] ext;
        ext = '0;
        if (!code[11]) begin
            ext = {{(SW-11){code[10]}}, code[10:0]};
        end else if (code == REG_ACC) begin
            ext = cur_acc;
        end else begin
            for (int unsigned k = 0; k < NUM_PORTS; k++)
                if (code == REG_PORT + 12'(k))
                    ext = {{(SW-PORT_W){1'b0}}, pins[k*PORT_W +: PORT_W]};
        end
        return sat(ext);
    endfunction

    always_ff @(posedge clk) begin
        if (!rst && prog_we)
            mem[prog_addr] <= prog_wdata;
    end

    assign instr = mem[pc];
    assign cond  = instr[29:28];
    assign op    = op_t'(instr[27:24]);
    assign opa   = instr[23:12];
    assign opb   = instr[11:0];

    always_comb begin
        val_a = operand(opa, acc, p_in);
        val_b = operand(opb, acc, p_in);
        wa    = acc;
        wb    = val_a;
        sum   = wa + wb;
        diff  = wa - wb;
        prod  = wa * wb;
        if (val_a < 0)
            port_val = '0;
        else if (val_a > PORT_MAX)
            port_val = PORT_MAX[PORT_W-1:0];
        else
            port_val = val_a[PORT_W-1:0];
        exec = (cond == 2'b00) || (cond == 2'b01 && flag_p) || (cond == 2'b10 && flag_m);
        seq_next = (pc == prog_last) ? '0 : pc + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc       <= '0;
            acc      <= '0;
            flag_p   <= 1'b0;
            flag_m   <= 1'b0;
            p_out    <= '0;
            p_oe     <= '0;
            sleeping <= 1'b0;
            slp_cnt  <= '0;
        end else if (!run) begin
            pc       <= '0;
            sleeping <= 1'b0;
            slp_cnt  <= '0;
        end else if (sleeping) begin
            // The stall ends on the edge that consumes its last counted cycle.
            if (slp_cnt <= DATA_W'(1)) begin
                sleeping <= 1'b0;
                slp_cnt  <= '0;
                pc       <= seq_next;
            end else begin
                slp_cnt <= slp_cnt - 1'b1;
            end
        end else begin
            pc <= seq_next;
            if (exec) begin
                case (op)
                    OP_MOV: begin
                        if (opb == REG_ACC)
                            acc <= val_a;
                        for (int unsigned k = 0; k < NUM_PORTS; k++) begin
                            if (opb == REG_PORT + 12'(k)) begin
                                p_out[k*PORT_W +: PORT_W] <= port_val;
                                p_oe[k] <= 1'b1;
                            end
                        end
                    end
                    OP_JMP: pc  <= opa[AW-1:0];
                    OP_ADD: acc <= sat(sum);
                    OP_SUB: acc <= sat(diff);
                    OP_MUL: acc <= sat(prod);
                    OP_NOT: acc <= (acc == '0) ? PORT_MAX : '0;
                    OP_TEQ: begin
                        flag_p <= (val_a == val_b);
                        flag_m <= (val_a != val_b);
                    end
                    OP_TGT: begin
                        flag_p <= (val_a > val_b);
                        flag_m <= !(val_a > val_b);
                    end
                    OP_TLT: begin
                        flag_p <= (val_a < val_b);
                        flag_m <= !(val_a < val_b);
                    end
                    OP_SLP: begin
                        if (val_a > 0) begin
                            sleeping <= 1'b1;
                            slp_cnt  <= val_a;
                            pc       <= pc;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mcx_core_param.sv
// Directed bench for mcx_core_param: stimulus pushes per-cycle expectations into a
// scoreboard queue, a negedge monitor pops and compares them against the core state.
module tb_mcx_core_param;

    logic        clk = 1'b0;
    logic        rst, run, prog_we;
    logic [3:0]  prog_addr, prog_last;
    logic [29:0] prog_wdata;
    logic [13:0] p_in;
    logic [13:0] p_out;
    logic [1:0]  p_oe;
    logic [3:0]  pc;
    logic signed [10:0] acc;
    logic        flag_p, flag_m, sleeping;

    mcx_core_param #(
        .NUM_PORTS(2), .PORT_W(7), .DATA_W(11), .ACC_MAX(999), .PROG_DEPTH(16)
    ) dut (
        .clk(clk), .rst(rst), .run(run), .prog_we(prog_we), .prog_addr(prog_addr),
        .prog_wdata(prog_wdata), .prog_last(prog_last), .p_in(p_in), .p_out(p_out),
        .p_oe(p_oe), .pc(pc), .acc(acc), .flag_p(flag_p), .flag_m(flag_m),
        .sleeping(sleeping)
    );

    always #5 clk = ~clk;

    typedef enum int {K_PC, K_ACC, K_FP, K_FM, K_P0, K_P1, K_OE, K_SLP} kind_t;
    typedef struct {
        int    cyc;
        kind_t kind;
        int    val;
        string name;
    } exp_t;

    exp_t sbq[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    localparam logic [11:0] R_ACC = 12'h801;
    localparam logic [11:0] R_P0  = 12'h810;
    localparam logic [11:0] R_P1  = 12'h811;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int actual(kind_t k);
        int v;
        case (k)
            K_PC:    v = int'(pc);
            K_ACC:   v = acc;
            K_FP:    v = int'(flag_p);
            K_FM:    v = int'(flag_m);
            K_P0:    v = int'(p_out[6:0]);
            K_P1:    v = int'(p_out[13:7]);
            K_OE:    v = int'(p_oe);
            default: v = int'(sleeping);
        endcase
        return v;
    endfunction

    exp_t e;
    int   act;
    always @(negedge clk) begin
        while (sbq.size() > 0 && sbq[0].cyc <= cyc) begin
            e = sbq.pop_front();
            checks++;
            if (e.cyc < cyc) begin
                errors++;
                $display("FAIL %s: expectation for cycle %0d not compared (now %0d)", e.name, e.cyc, cyc);
            end else begin
                act = actual(e.kind);
                if (act != e.val) begin
                    errors++;
                    $display("FAIL %s: cycle %0d got %0d expected %0d", e.name, cyc, act, e.val);
                end
            end
        end
    end

    task automatic ex(kind_t k, int v, string n);
        exp_t x;
        x.cyc  = cyc + 1;
        x.kind = k;
        x.val  = v;
        x.name = n;
        sbq.push_back(x);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [29:0] ins(logic [1:0] c, logic [3:0] o, logic [11:0] a, logic [11:0] b);
        return {c, o, a, b};
    endfunction

    function automatic logic [11:0] imm(int v);
        logic [31:0] t;
        t = v;
        return {1'b0, t[10:0]};
    endfunction

    task automatic load(int addr, logic [29:0] w);
        prog_we    = 1'b1;
        prog_addr  = 4'(addr);
        prog_wdata = w;
        tick();
        prog_we    = 1'b0;
    endtask

    initial begin
        rst = 1'b1; run = 1'b0; prog_we = 1'b0; prog_addr = '0; prog_wdata = '0;
        prog_last = '0; p_in = {7'd42, 7'd0};
        tick();
        ex(K_PC, 0, "rst_pc"); ex(K_ACC, 0, "rst_acc"); ex(K_FP, 0, "rst_fp");
        ex(K_FM, 0, "rst_fm"); ex(K_OE, 0, "rst_oe"); ex(K_SLP, 0, "rst_slp");
        tick();
        rst = 1'b0;

        // saturating arithmetic
        load(0, ins(2'b00, 4'h1, imm(50), R_ACC));
        load(1, ins(2'b00, 4'h3, imm(960), 12'h0));
        load(2, ins(2'b00, 4'h4, imm(1023), 12'h0));
        load(3, ins(2'b00, 4'h4, imm(1023), 12'h0));
        prog_last = 4'd3; run = 1'b1;
        ex(K_ACC, 50, "t1_mov"); ex(K_PC, 1, "t1_pc1"); tick();
        ex(K_ACC, 999, "t1_add_sat"); ex(K_PC, 2, "t1_pc2"); tick();
        ex(K_ACC, 0, "t1_sub"); ex(K_PC, 3, "t1_pc3"); tick();
        ex(K_ACC, -999, "t1_sub_sat"); ex(K_PC, 0, "t1_wrap"); tick();
        run = 1'b0;
        ex(K_PC, 0, "t1_hold_pc"); ex(K_ACC, -999, "t1_hold_acc"); tick();

        // test + conditional mov
        load(0, ins(2'b00, 4'h1, imm(0), R_ACC));
        load(1, ins(2'b00, 4'h7, R_ACC, imm(0)));
        load(2, ins(2'b01, 4'h1, imm(77), R_P0));
        load(3, ins(2'b10, 4'h1, imm(5), R_P0));
        prog_last = 4'd3; run = 1'b1;
        ex(K_ACC, 0, "t2_acc0"); tick();
        ex(K_FP, 1, "t2_fp"); ex(K_FM, 0, "t2_fm"); tick();
        ex(K_P0, 77, "t2_p0"); ex(K_OE, 1, "t2_oe"); tick();
        ex(K_P0, 77, "t2_skip_p0"); ex(K_PC, 0, "t2_wrap"); tick();
        run = 1'b0; tick();

        // sleep
        load(0, ins(2'b00, 4'hA, imm(3), 12'h0));
        load(1, ins(2'b00, 4'h3, imm(1), 12'h0));
        prog_last = 4'd1; run = 1'b1;
        ex(K_SLP, 1, "t3_slp1"); ex(K_PC, 0, "t3_pc_hold1"); tick();
        ex(K_SLP, 1, "t3_slp2"); ex(K_PC, 0, "t3_pc_hold2"); tick();
        ex(K_SLP, 1, "t3_slp3"); ex(K_ACC, 0, "t3_acc_hold"); tick();
        ex(K_SLP, 0, "t3_wake"); ex(K_PC, 1, "t3_pc_adv"); ex(K_ACC, 0, "t3_acc_pre"); tick();
        ex(K_ACC, 1, "t3_add"); ex(K_PC, 0, "t3_wrap"); tick();
        run = 1'b0;
        ex(K_SLP, 0, "t3_stop_slp"); ex(K_PC, 0, "t3_stop_pc"); tick();

        // jump
        load(0, ins(2'b00, 4'h2, 12'd5, 12'h0));
        load(5, ins(2'b00, 4'h3, imm(7), 12'h0));
        prog_last = 4'd5; run = 1'b1;
        ex(K_PC, 5, "t4_jmp1"); ex(K_ACC, 1, "t4_acc1"); tick();
        ex(K_PC, 0, "t4_wrap1"); ex(K_ACC, 8, "t4_add1"); tick();
        ex(K_PC, 5, "t4_jmp2"); tick();
        ex(K_PC, 0, "t4_wrap2"); ex(K_ACC, 15, "t4_add2"); tick();
        run = 1'b0; tick();

        // port read, mul saturation, port clamp, never-condition
        load(0, ins(2'b00, 4'h1, R_P1, R_ACC));
        load(1, ins(2'b00, 4'h5, imm(30), 12'h0));
        load(2, ins(2'b00, 4'h1, imm(150), R_P1));
        load(3, ins(2'b11, 4'h3, imm(5), 12'h0));
        prog_last = 4'd3; run = 1'b1;
        ex(K_ACC, 42, "t5_port_rd"); tick();
        ex(K_ACC, 999, "t5_mul_sat"); tick();
        ex(K_P1, 100, "t5_p1_clamp"); ex(K_OE, 3, "t5_oe"); ex(K_P0, 77, "t5_p0_keep"); tick();
        ex(K_ACC, 999, "t5_never"); ex(K_PC, 0, "t5_wrap"); tick();
        run = 1'b0; tick();

        // reset during sleep
        load(0, ins(2'b00, 4'hA, imm(10), 12'h0));
        run = 1'b1;
        ex(K_SLP, 1, "t6_slp1"); tick();
        ex(K_SLP, 1, "t6_slp2"); ex(K_PC, 0, "t6_pc"); tick();
        rst = 1'b1;
        ex(K_SLP, 0, "t6_rst_slp"); ex(K_PC, 0, "t6_rst_pc"); ex(K_ACC, 0, "t6_rst_acc");
        ex(K_OE, 0, "t6_rst_oe"); ex(K_P1, 0, "t6_rst_p1"); tick();
        rst = 1'b0;
        ex(K_SLP, 1, "t6_rerun_slp"); tick();
        run = 1'b0;
        ex(K_SLP, 0, "t6_abort_slp"); ex(K_PC, 0, "t6_abort_pc"); tick();

        // tgt/tlt, minus-conditioned adds, negative sleep, immediate clamp
        load(0, ins(2'b00, 4'h8, imm(5), imm(3)));
        load(1, ins(2'b10, 4'h3, imm(100), 12'h0));
        load(2, ins(2'b00, 4'h9, imm(5), imm(3)));
        load(3, ins(2'b10, 4'h3, imm(4), 12'h0));
        load(4, ins(2'b00, 4'hA, imm(-2), 12'h0));
        load(5, ins(2'b00, 4'h1, imm(-1024), R_ACC));
        prog_last = 4'd5; run = 1'b1;
        ex(K_FP, 1, "t7_tgt_fp"); ex(K_FM, 0, "t7_tgt_fm"); tick();
        ex(K_ACC, 0, "t7_skip"); ex(K_PC, 2, "t7_pc2"); tick();
        ex(K_FP, 0, "t7_tlt_fp"); ex(K_FM, 1, "t7_tlt_fm"); tick();
        ex(K_ACC, 4, "t7_cond_add"); tick();
        ex(K_SLP, 0, "t7_neg_slp"); ex(K_PC, 5, "t7_neg_slp_pc"); tick();
        ex(K_ACC, -999, "t7_imm_clamp"); ex(K_PC, 0, "t7_wrap"); tick();
        run = 1'b0;
        tick(); tick();

        while (sbq.size() > 0) begin
            e = sbq.pop_front();
            checks++;
            errors++;
            $display("FAIL %s: expectation for cycle %0d never compared", e.name, e.cyc);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
